// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM state type, round constants and the linear round helpers.
// State bytes are packed column-major with FIPS-197 byte 0 in bits [127:120].
package aes_pkg;

   typedef enum logic [1:0] {StIdle, StRound, StDone} aes_state_e;

   localparam logic [3:0] NumRounds = 4'd10;

   // Indexed directly by the 4-bit round counter; only entries 1..10 are meaningful.
   localparam logic [15:0][7:0] Rcon = {40'h0, 8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10,
                                        8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Row r of the state rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int rr = 0; rr < 4; rr++) begin
            r[127-8*(rr+4*c) -: 8] = s[127-8*(rr+4*((c+rr)%4)) -: 8];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/aes_encrypt_iter_if.sv
// Handshake bundle between a plaintext/key producer and the iterative AES-128 encryptor.
interface aes_encrypt_iter_if;

   logic         in_valid;
   logic         in_ready;
   logic [127:0] plaintext;
   logic [127:0] key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] ciphertext;
   logic         busy;

   modport master (
      output in_valid, plaintext, key, out_ready,
      input  in_ready, out_valid, ciphertext, busy
   );

   modport slave (
      input  in_valid, plaintext, key, out_ready,
      output in_ready, out_valid, ciphertext, busy
   );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] data,
   output logic [7:0] subst
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   logic [7:0] sq, inv;

   // inv = data^254 via square-and-multiply; maps 0 to 0 as AES requires.
   always_comb begin
      sq  = data;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
   end

   assign subst = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one full round per clock with the key schedule expanded on the fly.
module aes_encrypt_iter
   import aes_pkg::*;
(
   input logic              clk,
   input logic              rst,
   aes_encrypt_iter_if.slave bus
);

   aes_state_e   st_q;
   logic [3:0]   round_q;
   logic [127:0] state_q, rkey_q, ct_q;
   logic         in_ready_q, out_valid_q, busy_q;

   logic [127:0] sub_bytes, shifted, mixed, state_next, next_key;
   logic [31:0]  rot_word, sub_word, key_tmp;

   for (genvar i = 0; i < 16; i++) begin : g_state_sbox
      aes_sbox u_sbox (
         .data  (state_q[127-8*i -: 8]),
         .subst (sub_bytes[127-8*i -: 8])
      );
   end

   assign shifted = shift_rows(sub_bytes);

   for (genvar c = 0; c < 4; c++) begin : g_mix
      assign mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
   end

   assign rot_word = {rkey_q[23:0], rkey_q[31:24]};

   for (genvar j = 0; j < 4; j++) begin : g_key_sbox
      aes_sbox u_sbox (
         .data  (rot_word[31-8*j -: 8]),
         .subst (sub_word[31-8*j -: 8])
      );
   end

   assign key_tmp            = sub_word ^ {Rcon[round_q], 24'h0};
   assign next_key[127:96]   = rkey_q[127:96] ^ key_tmp;
   assign next_key[95:64]    = rkey_q[95:64] ^ next_key[127:96];
   assign next_key[63:32]    = rkey_q[63:32] ^ next_key[95:64];
   assign next_key[31:0]     = rkey_q[31:0] ^ next_key[63:32];

   assign state_next = ((round_q == NumRounds) ? shifted : mixed) ^ next_key;

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q        <= StIdle;
         round_q     <= '0;
         state_q     <= '0;
         rkey_q      <= '0;
         ct_q        <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (st_q)
            StIdle: begin
               if (bus.in_valid && in_ready_q) begin
                  state_q    <= bus.plaintext ^ bus.key;
                  rkey_q     <= bus.key;
                  round_q    <= 4'd1;
                  st_q       <= StRound;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            StRound: begin
               state_q <= state_next;
               rkey_q  <= next_key;
               if (round_q == NumRounds) begin
                  st_q        <= StDone;
                  ct_q        <= state_next;
                  out_valid_q <= 1'b1;
               end else begin
                  round_q <= round_q + 4'd1;
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  st_q        <= StIdle;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: st_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.ciphertext = ct_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Self-checking bench for aes_encrypt_iter: FIPS-197 vectors, handshake corner cases and
// random blocks scored against a byte-array AES-128 reference model.
module tb_aes_encrypt_iter;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   aes_encrypt_iter_if bus ();

   aes_encrypt_iter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CtZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic [7:0] sbox_tbl [256];

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s, c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sbox_tbl[x] = s;
      end
   endtask

   function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_tbl[tmp[31:24]], sbox_tbl[tmp[23:16]], sbox_tbl[tmp[15:8]],
                   sbox_tbl[tmp[7:0]]};
            tmp = tmp ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_tbl[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
         for (int i = 0; i < 16; i++) s[i] = t[i];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Cycle 1 is the cycle right after the accept edge; out_valid must first appear in cycle 11.
   task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                            input logic [127:0] exp, input int hold);
      int cyc;
      bus.plaintext = pt;
      bus.key       = k;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      cyc = 0;
      while (!bus.in_ready && cyc < 30) begin
         step();
         cyc++;
      end
      check_eq({tag, "/ready_before_accept"}, 128'(bus.in_ready), 128'(1));
      step();
      cyc = 1;
      check_eq({tag, "/busy_in_round"}, 128'(bus.busy), 128'(1));
      check_eq({tag, "/in_ready_in_round"}, 128'(bus.in_ready), 128'(0));
      while (!bus.out_valid && cyc < 30) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.plaintext = rand128();
         bus.key       = rand128();
         step();
         cyc++;
      end
      check_eq({tag, "/latency"}, 128'(cyc), 128'(11));
      check_eq({tag, "/ciphertext"}, bus.ciphertext, exp);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.plaintext = rand128();
         bus.key       = rand128();
         step();
         check_eq({tag, "/hold_out_valid"}, 128'(bus.out_valid), 128'(1));
         check_eq({tag, "/hold_ciphertext"}, bus.ciphertext, exp);
         check_eq({tag, "/hold_in_ready"}, 128'(bus.in_ready), 128'(0));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check_eq({tag, "/exit_out_valid"}, 128'(bus.out_valid), 128'(0));
      check_eq({tag, "/exit_in_ready"}, 128'(bus.in_ready), 128'(1));
      check_eq({tag, "/exit_busy"}, 128'(bus.busy), 128'(0));
      check_eq({tag, "/idle_ct_held"}, bus.ciphertext, exp);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int           t, n_acc, n_ct, exit_t, seen;
      int           acc [2];
      logic [127:0] cts [2];
      logic [127:0] pt, k;
      logic         rdy_b, ov_b;

      n_tests = 0;
      n_fail  = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.plaintext = '0;
      bus.key       = '0;
      build_sbox();
      repeat (3) step();
      check_eq("reset/in_ready", 128'(bus.in_ready), 128'(1));
      check_eq("reset/out_valid", 128'(bus.out_valid), 128'(0));
      check_eq("reset/busy", 128'(bus.busy), 128'(0));
      check_eq("reset/ciphertext", bus.ciphertext, 128'(0));
      rst = 1'b0;
      step();
      check_eq("post_reset/in_ready", 128'(bus.in_ready), 128'(1));

      run_block("fips_b_backpressure", PtB, KeyB, CtB, 20);
      run_block("fips_c1", PtC, KeyC, CtC, 0);
      run_block("all_zero", 128'(0), 128'(0), CtZ, 2);

      // Abort a block while the round counter sits at 5.
      bus.plaintext = PtB;
      bus.key       = KeyB;
      bus.in_valid  = 1'b1;
      step();
      bus.in_valid = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("midreset/in_ready", 128'(bus.in_ready), 128'(1));
      check_eq("midreset/out_valid", 128'(bus.out_valid), 128'(0));
      check_eq("midreset/busy", 128'(bus.busy), 128'(0));
      check_eq("midreset/ciphertext", bus.ciphertext, 128'(0));
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (bus.out_valid) seen = 1;
      end
      check_eq("midreset/no_out_valid", 128'(seen), 128'(0));
      run_block("after_midreset_b", PtB, KeyB, CtB, 1);

      // Back-to-back: in_valid and out_ready held high across two blocks.
      bus.plaintext = PtB;
      bus.key       = KeyB;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      t = 0; n_acc = 0; n_ct = 0; exit_t = -1;
      acc[0] = 0; acc[1] = 0; cts[0] = '0; cts[1] = '0;
      while ((n_acc < 2 || n_ct < 2) && t < 80) begin
         rdy_b = bus.in_ready;
         ov_b  = bus.out_valid;
         step();
         t++;
         if (rdy_b && n_acc < 2) begin
            acc[n_acc] = t;
            n_acc++;
            if (n_acc == 1) begin
               bus.plaintext = PtC;
               bus.key       = KeyC;
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         if (ov_b && exit_t < 0) exit_t = t;
         if (bus.out_valid && !ov_b && n_ct < 2) begin
            cts[n_ct] = bus.ciphertext;
            n_ct++;
         end
      end
      bus.in_valid  = 1'b0;
      check_eq("b2b/completed_in_budget", 128'(t < 80), 128'(1));
      check_eq("b2b/ct_first", cts[0], CtB);
      check_eq("b2b/ct_second", cts[1], CtC);
      check_eq("b2b/accept_period", 128'(acc[1] - acc[0]), 128'(12));
      check_eq("b2b/accept_after_exit", 128'(acc[1] - exit_t), 128'(1));
      repeat (3) step();
      bus.out_ready = 1'b0;

      for (int n = 0; n < 8; n++) begin
         pt = rand128();
         k  = rand128();
         run_block($sformatf("random%0d", n), pt, k, ref_encrypt(pt, k),
                   int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_encrypt_iter.md
AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 Parameters: none; block is fixed AES-128.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  plaintext/key offered.
REQ-005 in_ready  output  1  block can accept; high only in IDLE.
REQ-006 plaintext  input  128  input block; [127:120] is FIPS-197 byte 0, column-major.
REQ-007 key  input  128  cipher key; same byte order as plaintext.
REQ-008 out_valid  output  1  ciphertext valid; held until consumed.
REQ-009 out_ready  input  1  consumer accepts ciphertext.
REQ-010 ciphertext  output  128  result block; same byte order as plaintext.
REQ-011 busy  output  1  high in ROUND or DONE.

Function
REQ-012 The block SHALL implement the forward AES-128 cipher (FIPS-197): SubBytes, ShiftRows, MixColumns, AddRoundKey; it pairs with the team's inverse-cipher datapath.
REQ-013 FSM states SHALL be IDLE, ROUND and DONE.
REQ-014 IDLE: on in_valid && in_ready, register state = plaintext XOR key and round key = key, set round counter to 1, go to ROUND.
REQ-015 ROUND: each cycle, apply one full round to the state with the next round key, computed on the fly from the current round key.
REQ-016 Round counter SHALL count 1..10; rounds 1-9 include MixColumns; round 10 omits MixColumns.
REQ-017 Key schedule SHALL use RotWord, SubWord and Rcon; Rcon for rounds 1..10 = 01,02,04,08,10,20,40,80,1b,36.
REQ-018 After round 10, FSM SHALL go to DONE with ciphertext = final state and out_valid = 1.
REQ-019 Latency: out_valid SHALL rise exactly 11 cycles after the accept edge.
REQ-020 DONE: out_valid and ciphertext SHALL stay stable while out_ready = 0.
REQ-021 DONE: on out_ready = 1, return to IDLE next cycle; in_ready rises in that cycle.
REQ-022 No new input SHALL be accepted in ROUND or DONE; in_valid there is ignored and not queued.
REQ-023 Throughput: one block per 12 cycles minimum, with out_ready held high.
REQ-024 plaintext and key are sampled only on the accept edge; later changes SHALL NOT affect the result.
REQ-025 ciphertext SHALL hold its last value in IDLE; only out_valid qualifies it.

Reset
REQ-026 On rst, FSM SHALL go to IDLE, round counter to 0, and state, round key and ciphertext to 0.
REQ-027 Output reset values: in_ready = 1 (first cycle after reset release), out_valid = 0, busy = 0, ciphertext = 0.
REQ-028 rst mid-ROUND or in DONE SHALL abort the operation; no out_valid pulse follows.
REQ-029 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-030 Shared package aes_pkg SHALL hold: FSM state typedef, the Rcon table, the round-count constant (10), and functions xtime, mix_column, shift_rows.
REQ-031 Forward S-box SHALL be one sub-module, aes_sbox (8-bit in, 8-bit out, combinational).
REQ-032 aes_sbox SHALL be instantiated 20 times: 16 for state SubBytes, 4 for key SubWord.
REQ-033 No other sub-modules SHALL be used; all datapath registers live in aes_encrypt_iter.

Verification
REQ-034 FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> ct 3925841d02dc09fbdc118597196a0b32, out_valid 11 cycles after accept.
REQ-035 FIPS-197 App. C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> ct 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-036 All-zero pt and key -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
REQ-037 Back-pressure: hold out_ready = 0 for 20 cycles after out_valid -> ciphertext and out_valid stable, in_ready = 0, and changes on in_valid/plaintext ignored throughout.
REQ-038 Reset mid-op: assert rst at round 5 -> next cycle in_ready = 1, out_valid = 0; then App. B vectors -> correct ct.
REQ-039 Back-to-back: B then C.1 with in_valid and out_ready held high -> both ciphertexts correct; second accept occurs one cycle after the first DONE exit.
